seg_capture: RTL and testbench

SEG_CAPTURE -- requirements
Module: seg_capture

---
 rtl/seg_capture.sv | 168 ++++++++++++++++
 tb/tb_seg_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : seg_capture
// Purpose  : Debounced 7-segment pattern capture with BCD decode into a 4-deep FIFO.
// Revision : 1.0
// ============================================================================
module seg_capture #(
  parameter int STABLE = 4
) (
  input  logic       CP,
  input  logic       MRN,
  input  logic [7:0] Seg,
  input  logic       Ack,
  input  logic       Clr,
  output logic [3:0] Qn,
  output logic       Valid,
  output logic       Blank,
  output logic       Err,
  output logic       Ovf,
  output logic [3:0] ErrCnt
);

  localparam logic [3:0] c_hold_max  = 4'(STABLE);
  localparam logic [3:0] c_hold_fire = 4'(STABLE - 1);
  localparam logic [2:0] c_depth     = 3'd4;

  logic [6:0] r_s1;
  logic [6:0] r_s2;
  logic [6:0] r_s2_prev;
  logic [6:0] r_last_pat;
  logic [3:0] r_hold;
  logic [3:0] r_mem [4];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       r_blank;
  logic       r_err;
  logic       r_ovf;
  logic [3:0] r_err_cnt;

  logic       w_changed;
  logic       w_accept;
  logic       w_legal;
  logic [3:0] w_digit;
  logic       w_blank_pat;
  logic       w_illegal;
  logic       w_push;
  logic       w_pop;
  logic       w_drop;
  logic       w_write;
  logic       w_unused;

  // The decimal point plays no part in decoding.
  assign w_unused = Seg[7];

  assign w_changed   = (r_s2 != r_s2_prev);
  assign w_accept    = !w_changed && (r_hold == c_hold_fire) && (r_s2 != r_last_pat);
  assign w_blank_pat = (r_s2 == 7'h00);
  assign w_illegal   = w_accept && !w_legal && !w_blank_pat;
  assign w_push      = w_accept && w_legal;
  assign w_pop       = Ack && (r_count != 3'd0);
  assign w_drop      = w_push && (r_count == c_depth) && !w_pop;
  assign w_write     = w_push && !w_drop;

  always_comb begin
    w_legal = 1'b1;
    w_digit = 4'd0;
    case (r_s2)
      7'h3F:        w_digit = 4'd0;
      7'h06:        w_digit = 4'd1;
      7'h5B:        w_digit = 4'd2;
      7'h4F:        w_digit = 4'd3;
      7'h66:        w_digit = 4'd4;
      7'h6D:        w_digit = 4'd5;
      7'h7C, 7'h7D: w_digit = 4'd6;
      7'h07:        w_digit = 4'd7;
      7'h7F:        w_digit = 4'd8;
      7'h67, 7'h6F: w_digit = 4'd9;
      default:      w_legal = 1'b0;
    endcase
  end

  // Synchroniser, hold counter and accepted-pattern history.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      r_s1       <= 7'h00;
      r_s2       <= 7'h00;
      r_s2_prev  <= 7'h00;
      r_last_pat <= 7'h00;
      r_hold     <= 4'd0;
    end else begin
      r_s1      <= Seg[6:0];
      r_s2      <= r_s1;
      r_s2_prev <= r_s2;
      if (w_changed) begin
        r_hold <= 4'd1;
      end else if (r_hold != c_hold_max) begin
        r_hold <= r_hold + 4'd1;
      end
      if (w_accept) begin
        r_last_pat <= r_s2;
      end
    end
  end

  // Status flags; Clr overrides any set on the same edge.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      r_blank   <= 1'b1;
      r_err     <= 1'b0;
      r_ovf     <= 1'b0;
      r_err_cnt <= 4'd0;
    end else begin
      if (w_accept) begin
        r_blank <= w_blank_pat;
      end
      if (Clr) begin
        r_err     <= 1'b0;
        r_ovf     <= 1'b0;
        r_err_cnt <= 4'd0;
      end else begin
        if (w_illegal) begin
          r_err <= 1'b1;
          if (r_err_cnt != 4'hF) begin
            r_err_cnt <= r_err_cnt + 4'd1;
          end
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

  // When full, a simultaneous push overwrites the slot being popped.
  always_ff @(posedge CP or negedge MRN) begin
    if (!MRN) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 4'd0;
      end
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_write) begin
        r_mem[r_wr_ptr] <= w_digit;
        r_wr_ptr        <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign Qn     = r_mem[r_rd_ptr];
  assign Valid  = (r_count != 3'd0);
  assign Blank  = r_blank;
  assign Err    = r_err;
  assign Ovf    = r_ovf;
  assign ErrCnt = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_seg_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_capture
// Purpose  : Table-driven directed bench for seg_capture (STABLE = 4).
// Revision : 1.0
// ============================================================================
module tb_seg_capture;

  logic       CP;
  logic       MRN;
  logic [7:0] Seg;
  logic       Ack;
  logic       Clr;
  logic [3:0] Qn;
  logic       Valid;
  logic       Blank;
  logic       Err;
  logic       Ovf;
  logic [3:0] ErrCnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0] seg;
    logic       ack;
    logic       clr;
    int         cyc;
    logic       valid;
    logic [3:0] qn;
    logic       blank;
    logic       err;
    logic       ovf;
    logic [3:0] cnt;
  } vec_t;

  vec_t tbl[$];

  seg_capture #(.STABLE(4)) dut (
    .CP     (CP),
    .MRN    (MRN),
    .Seg    (Seg),
    .Ack    (Ack),
    .Clr    (Clr),
    .Qn     (Qn),
    .Valid  (Valid),
    .Blank  (Blank),
    .Err    (Err),
    .Ovf    (Ovf),
    .ErrCnt (ErrCnt)
  );

  initial CP = 1'b0;
  always #5 CP = ~CP;

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic void add(input logic [7:0] seg, input logic ack, input logic clr, input int cyc,
                              input logic valid, input logic [3:0] qn, input logic blank,
                              input logic err, input logic ovf, input logic [3:0] cnt);
    vec_t v;
    v.seg = seg; v.ack = ack; v.clr = clr; v.cyc = cyc; v.valid = valid;
    v.qn = qn; v.blank = blank; v.err = err; v.ovf = ovf; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  initial begin
    // seg, ack, clr, cycles | valid, qn, blank, err, ovf, errcnt
    add(8'hDB, 0, 0, 5, 0, 0, 1, 0, 0, 0);   // dp set, still 0x5B; not yet accepted
    add(8'hDB, 0, 0, 1, 1, 2, 0, 0, 0, 0);   // accepted on 6th edge
    add(8'hDB, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(8'hDB, 1, 0, 2, 0, 0, 0, 0, 0, 0);   // Ack while empty ignored
    for (int k = 0; k < 10; k++) begin
      add((k % 2 == 0) ? 8'h07 : 8'h06, 0, 0, 2, 0, 0, 0, 0, 0, 0);
    end
    add(8'h07, 0, 0, 6, 1, 7, 0, 0, 0, 0);
    add(8'h07, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // overflow
    add(8'h3F, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h06, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h5B, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h4F, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h66, 0, 0, 6, 1, 0, 0, 0, 1, 0);
    add(8'h66, 1, 0, 1, 1, 1, 0, 0, 1, 0);
    add(8'h66, 1, 0, 1, 1, 2, 0, 0, 1, 0);
    add(8'h66, 1, 0, 1, 1, 3, 0, 0, 1, 0);
    add(8'h66, 1, 0, 1, 0, 0, 0, 0, 1, 0);
    add(8'h66, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // illegal codes and blank
    add(8'h49, 0, 0, 6, 0, 0, 0, 1, 0, 1);
    add(8'h00, 0, 0, 6, 0, 0, 1, 1, 0, 1);
    add(8'h49, 0, 0, 6, 0, 0, 0, 1, 0, 2);
    add(8'h49, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // alternate digit forms
    add(8'h7C, 0, 0, 6, 1, 6, 0, 0, 0, 0);
    add(8'h7D, 0, 0, 6, 1, 6, 0, 0, 0, 0);
    add(8'h67, 0, 0, 6, 1, 6, 0, 0, 0, 0);
    add(8'h6F, 0, 0, 6, 1, 6, 0, 0, 0, 0);
    add(8'h6F, 1, 0, 1, 1, 6, 0, 0, 0, 0);
    add(8'h6F, 1, 0, 1, 1, 9, 0, 0, 0, 0);
    add(8'h6F, 1, 0, 1, 1, 9, 0, 0, 0, 0);
    add(8'h6F, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // push and pop on the same edge while full
    add(8'h3F, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h06, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h5B, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h4F, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h66, 0, 0, 5, 1, 0, 0, 0, 0, 0);
    add(8'h66, 1, 0, 1, 1, 1, 0, 0, 0, 0);
    add(8'h66, 1, 0, 1, 1, 2, 0, 0, 0, 0);
    add(8'h66, 1, 0, 1, 1, 3, 0, 0, 0, 0);
    add(8'h66, 1, 0, 1, 1, 4, 0, 0, 0, 0);
    add(8'h66, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    // illegal accept on a Clr edge, then no re-fire of the held pattern
    add(8'h49, 0, 0, 5, 0, 0, 0, 0, 0, 0);
    add(8'h49, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    add(8'h49, 0, 0, 3, 0, 0, 0, 0, 0, 0);
    // three entries queued ahead of the reset sequence
    add(8'h3F, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h06, 0, 0, 6, 1, 0, 0, 0, 0, 0);
    add(8'h5B, 0, 0, 6, 1, 0, 0, 0, 0, 0);

    MRN = 1'b0;
    Seg = 8'h00;
    Ack = 1'b0;
    Clr = 1'b0;
    @(negedge CP);
    chk("rst_valid", -1, {7'd0, Valid}, 8'd0);
    chk("rst_blank", -1, {7'd0, Blank}, 8'd1);
    chk("rst_err", -1, {7'd0, Err}, 8'd0);
    chk("rst_ovf", -1, {7'd0, Ovf}, 8'd0);
    chk("rst_errcnt", -1, {4'd0, ErrCnt}, 8'd0);
    chk("rst_qn", -1, {4'd0, Qn}, 8'd0);
    MRN = 1'b1;

    foreach (tbl[i]) begin
      Seg = tbl[i].seg;
      Ack = tbl[i].ack;
      Clr = tbl[i].clr;
      repeat (tbl[i].cyc) @(posedge CP);
      @(negedge CP);
      chk("valid", i, {7'd0, Valid}, {7'd0, tbl[i].valid});
      if (tbl[i].valid) chk("qn", i, {4'd0, Qn}, {4'd0, tbl[i].qn});
      chk("blank", i, {7'd0, Blank}, {7'd0, tbl[i].blank});
      chk("err", i, {7'd0, Err}, {7'd0, tbl[i].err});
      chk("ovf", i, {7'd0, Ovf}, {7'd0, tbl[i].ovf});
      chk("errcnt", i, {4'd0, ErrCnt}, {4'd0, tbl[i].cnt});
    end

    // Asynchronous reset in mid-cycle must act before the next CP edge.
    #2;
    MRN = 1'b0;
    Seg = 8'h7F;
    Ack = 1'b0;
    Clr = 1'b0;
    #1;
    chk("async_valid", 100, {7'd0, Valid}, 8'd0);
    chk("async_blank", 100, {7'd0, Blank}, 8'd1);
    chk("async_qn", 100, {4'd0, Qn}, 8'd0);
    @(negedge CP);
    MRN = 1'b1;
    repeat (5) @(posedge CP);
    @(negedge CP);
    chk("post_rst_valid5", 101, {7'd0, Valid}, 8'd0);
    @(posedge CP);
    @(negedge CP);
    chk("post_rst_valid6", 102, {7'd0, Valid}, 8'd1);
    chk("post_rst_qn", 102, {4'd0, Qn}, 8'd8);
    chk("post_rst_blank", 102, {7'd0, Blank}, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
